// File: rtl/spart_tx_fifo.sv
// Byte FIFO between the SPART bus write path and the serial transmitter; DEPTH x 8 register storage.
// Latency: byte pushed into an empty FIFO at edge n (tbr=1) is presented with tx_write after edge n+1.
// Backpressure: pops wait on tbr; a push while full with no same-cycle pop is dropped (optional sticky flag SPART_TX_OVF_FLAG_EN).
module spart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              tbr,
    output logic              tx_write,
    output logic [7:0]        tx_data,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_t            state_q, state_d;
    logic              tx_write_q, tx_write_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              pop;
    logic              push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;

    // A pop needs the FSM idle, something queued and the transmitter ready.
    // empty is the pre-push value, so a byte pushed this cycle is not popped this cycle.
    assign pop  = (state_q == IDLE) && !empty && tbr;
    // A same-cycle pop frees the slot a push into a full FIFO needs; when full the
    // read and write pointers coincide, and the pop reads the old byte before it is overwritten.
    assign push = wr_en && (!full || pop);

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM next state: LOAD absorbs the cycle before the transmitter drops tbr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? LOAD : IDLE;
            LOAD:    state_d = BUSY;
            BUSY:    state_d = tbr ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: load strobe only on the popping cycle, data held between pops.
    always_comb begin
        tx_write_d = pop;
        tx_data_d  = tx_data_q;
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
        end
    end

    // State, pointers and registered transmitter outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef SPART_TX_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop     = wr_en && full && !pop;
    assign overflow = ovf_q;

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    logic unused_clr_ovf;

    assign unused_clr_ovf = clr_ovf;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Self-checking bench for spart_tx_fifo: directed vector table, corner sequences, random run vs queue model.
// Outputs sampled 1 time unit after each rising edge; inputs driven there too.
// Every cycle compares all outputs with the model.
module tb_spart_tx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full, empty;
    logic [ADDR_W:0]   count;
    logic              tbr = 1'b0;
    logic              tx_write;
    logic [7:0]        tx_data;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    spart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tbr      (tbr),
        .tx_write (tx_write),
        .tx_data  (tx_data),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SPART_TX_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // Behavioural model: byte queue plus a "transmitter slot" lock.
    // After a pop the slot stays locked for at least two edges, then until tbr is seen high.
    logic [7:0] mq[$];
    logic [7:0] out_log[$];
    bit         m_lock;
    int         m_age;
    bit         m_txw;
    logic [7:0] m_txd;
    bit         m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lock = 1'b0;
        m_age  = 0;
        m_txw  = 1'b0;
        m_txd  = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all();
        check("tx_write", 32'(tx_write), 32'(m_txw));
        check("tx_data",  32'(tx_data),  32'(m_txd));
        check("count",    32'(count),    32'(mq.size()));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("overflow", 32'(overflow), 32'(OVF_EN & m_ovf));
    endtask

    // One clock with the given inputs; the model advances alongside and all outputs are compared.
    task automatic cycle(input logic w, input logic [7:0] d, input logic t, input logic c);
        bit full_pre, do_pop, do_push, drop;
        wr_en = w; wr_data = d; tbr = t; clr_ovf = c;
        full_pre = (mq.size() == DEPTH);
        do_pop   = !m_lock && (mq.size() > 0) && t;
        do_push  = w && (!full_pre || do_pop);
        drop     = w && full_pre && !do_pop;
        if (do_pop) begin
            m_txd  = mq.pop_front();
            m_lock = 1'b1;
            m_age  = 0;
        end else if (m_lock) begin
            m_age++;
            if (m_age >= 2 && t) m_lock = 1'b0;
        end
        m_txw = do_pop;
        if (do_push) mq.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        if (tx_write === 1'b1) out_log.push_back(tx_data);
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        wr_en = 1'b0; clr_ovf = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_tx_write", 32'(tx_write), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        out_log.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 200 && out_log.size() < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_count", 32'(out_log.size()), 32'(n));
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       t;
        logic       exp_txw;
        logic [7:0] exp_txd;
        int         exp_cnt;
    } vec_t;

    vec_t tv[9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        logic prev_w;
        logic tb_r;
        int   pulses, last_pulse, min_gap;

        model_reset();
        #1;
        check("init_empty",    32'(empty),    32'd1);
        check("init_count",    32'(count),    32'd0);
        check("init_tx_write", 32'(tx_write), 32'd0);
        check("init_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single byte, then a second byte that waits for the transmitter to finish.
        tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1};
        tv[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 0};
        tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
        tv[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1};
        tv[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1};
        tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1};
        tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 0};
        tv[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 0};
        tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 0};
        for (int i = 0; i < 9; i++) begin
            cycle(tv[i].w, tv[i].d, tv[i].t, 1'b0);
            check($sformatf("vec%0d_tx_write", i), 32'(tx_write), 32'(tv[i].exp_txw));
            check($sformatf("vec%0d_tx_data", i),  32'(tx_data),  32'(tv[i].exp_txd));
            check($sformatf("vec%0d_count", i),    32'(count),    32'(tv[i].exp_cnt));
        end

        // Fill with transmitter busy, drop the ninth byte, drain in order, then wrap pointers.
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        cycle(1'b1, 8'h09, 1'b0, 1'b0);
        check("drop_count", 32'(count), 32'd8);
        drain(8);
        for (int i = 0; i < out_log.size(); i++) check("fill_order", 32'(out_log[i]), 32'(i + 1));
        out_log.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        check("wrap_full", 32'(full), 32'd1);
        drain(8);
        for (int i = 0; i < out_log.size(); i++) check("wrap_order", 32'(out_log[i]), 32'h11 + 32'(i));

        // Push and pop in the same cycle while full.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h29, 1'b1, 1'b0);
        check("pushpop_count", 32'(count), 32'd8);
        check("pushpop_txd", 32'(tx_data), 32'h21);
        drain(9);
        for (int i = 0; i < out_log.size(); i++) check("pushpop_order", 32'(out_log[i]), 32'h21 + 32'(i));

        // Pulse spacing with tbr held high.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        pulses = 0; last_pulse = -100; min_gap = 1000; prev_w = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (tx_write === 1'b1) begin
                if (prev_w) check("pulse_width", 32'd2, 32'd1);
                if (i - last_pulse < min_gap) min_gap = i - last_pulse;
                last_pulse = i;
                pulses++;
            end
            prev_w = tx_write;
        end
        check("pulse_count", 32'(pulses), 32'd3);
        check("pulse_gap_ge2", 32'(min_gap >= 2), 32'd1);

        // Sticky overflow flag.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h5F, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'(OVF_EN));
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_hold", 32'(overflow), 32'(OVF_EN));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        cycle(1'b1, 8'h5E, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'(OVF_EN));

        // Reset while the transmitter is still busy: tbr low blocks pops afterwards.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_no_pop", 32'(tx_write), 32'd0);
        drain(1);

        // Random traffic against the model, with occasional asynchronous resets.
        tb_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) tb_r = ~tb_r;
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(1'($urandom_range(0, 1)), 8'($urandom), tb_r, 1'($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
